uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART receiver. It detects each new received character from the receiver's level-style valid strobe and stores the data byte with its parity-error flag. It presents entries to the host logic through a first-word-fall-through valid/ready interface. It also tracks overflow with a sticky flag and a saturating drop counter.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_fifo_mem.sv | 21 ++
 rtl/uart_rx_fifo.sv | 97 +++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-FIFO entry layout.
package uart_pkg;
  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 16;
  localparam int DROP_CNT_W        = 8;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int W      = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected writes, FWFT
// valid/ready output, sticky overflow flag and saturating drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = UART_RXFIFO_DEPTH,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_vld,
  input  logic                  rx_err,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_err,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_ovf
);
  // Output handshake: an entry transfers on a clk edge where out_vld & out_rdy.
  logic              rx_vld_d;
  logic              armed;
  logic              wr_evt;
  logic              pop;
  logic              wr_acc;
  logic              ovf_evt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W:0]   rd_entry;

  // armed stays low for the first edge after reset so an rx_vld already
  // high at release is treated as old, not as a new character.
  assign wr_evt  = rx_vld & ~rx_vld_d & armed;
  assign pop     = out_vld & out_rdy;
  assign wr_acc  = wr_evt & (~full | pop);
  assign ovf_evt = wr_evt & full & ~pop;

  assign full        = (count == (ADDR_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= (ADDR_W+1)'(AF_LEVEL));
  assign out_vld     = ~empty;
  assign out_data    = out_vld ? rd_entry[DATA_W-1:0] : '0;
  assign out_err     = out_vld ? rd_entry[DATA_W] : 1'b0;

  uart_fifo_mem #(
    .W      (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data ({rx_err, rx_data}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_vld_d <= 1'b0;
      armed    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      rx_vld_d <= rx_vld;
      armed    <= 1'b1;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !pop)      count <= count + 1'b1;
      else if (pop && !wr_acc) count <= count - 1'b1;
    end
  end

  // Overflow set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (ovf_evt) begin
      ovf <= 1'b1;
      if (clr_ovf)              drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end else if (clr_ovf) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed characters, expected-entry queue,
// negedge monitor comparing every popped head entry.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_err;
  logic [7:0] out_data;
  logic       out_err;
  logic       out_vld;
  logic       out_rdy;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       ovf;
  logic [7:0] drop_cnt;
  logic       clr_ovf;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .rx_err      (rx_err),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt),
    .clr_ovf     (clr_ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h expected none", {out_err, out_data});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({out_err, out_data} !== e) begin
          fails++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", {out_err, out_data}, e, $time);
        end
      end
    end
  end

  // One character: rx_vld high for hold cycles, then low for two.
  task automatic send(input logic [7:0] d, input logic e, input bit store, input int hold);
    @(posedge clk); #1;
    rx_data = d;
    rx_err  = e;
    rx_vld  = 1'b1;
    if (store) exp_q.push_back({e, d});
    repeat (hold) @(posedge clk);
    #1 rx_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    @(posedge clk); #1 out_rdy = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (empty) done = 1;
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_queue_left", exp_q.size(), 0);
    @(posedge clk); #1 out_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_data = '0; rx_vld = 1'b0; rx_err = 1'b0;
    out_rdy = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: long rx_vld gives one entry, visible one clk after the write edge
    @(posedge clk); #1;
    rx_data = 8'hA5; rx_err = 1'b0; rx_vld = 1'b1;
    exp_q.push_back(9'h0A5);
    @(negedge clk);
    chk("t1_vld_before", int'(out_vld), 0);
    @(negedge clk);
    chk("t1_vld_after", int'(out_vld), 1);
    chk("t1_count", int'(count), 1);
    chk("t1_head", int'(out_data), 8'hA5);
    chk("t1_err", int'(out_err), 0);
    repeat (198) @(posedge clk);
    @(negedge clk);
    chk("t1_count_held", int'(count), 1);
    @(posedge clk); #1 rx_vld = 1'b0;
    drain();

    // 2: fill, almost_full threshold, overflow, ordered drain
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), 1'b0, 1'b1, 2);
      if (i == 11) chk("t2_af_11", int'(almost_full), 0);
      if (i == 12) chk("t2_af_12", int'(almost_full), 1);
    end
    chk("t2_full", int'(full), 1);
    chk("t2_count", int'(count), 16);
    chk("t2_ovf_pre", int'(ovf), 0);
    send(8'h11, 1'b0, 1'b0, 2);
    chk("t2_ovf", int'(ovf), 1);
    chk("t2_drop", int'(drop_cnt), 1);
    chk("t2_count_ovf", int'(count), 16);
    drain();
    pulse_clr();
    @(negedge clk);
    chk("t2_clr_ovf", int'(ovf), 0);

    // 3: write coincident with pop while full
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    out_rdy = 1'b1; rx_data = 8'h55; rx_err = 1'b0; rx_vld = 1'b1;
    exp_q.push_back(9'h055);
    @(posedge clk); #1 out_rdy = 1'b0;
    @(negedge clk);
    chk("t3_count", int'(count), 16);
    chk("t3_full", int'(full), 1);
    chk("t3_ovf", int'(ovf), 0);
    @(posedge clk); #1 rx_vld = 1'b0;
    drain();

    // 4: parity-error flag travels with its character
    send(8'h3C, 1'b1, 1'b1, 3);
    send(8'hC3, 1'b0, 1'b1, 3);
    @(negedge clk);
    chk("t4_head_err", int'(out_err), 1);
    drain();

    // 5: drop counter saturation, clear, clear coincident with overflow
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0, 1'b1, 1);
    for (int i = 0; i < 300; i++) send(8'(i), 1'b0, 1'b0, 1);
    @(negedge clk);
    chk("t5_drop_sat", int'(drop_cnt), 255);
    chk("t5_ovf", int'(ovf), 1);
    pulse_clr();
    @(negedge clk);
    chk("t5_clr_ovf", int'(ovf), 0);
    chk("t5_clr_drop", int'(drop_cnt), 0);
    @(posedge clk); #1;
    clr_ovf = 1'b1; rx_data = 8'h99; rx_vld = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0; rx_vld = 1'b0;
    @(negedge clk);
    chk("t5_set_wins_ovf", int'(ovf), 1);
    chk("t5_set_wins_drop", int'(drop_cnt), 1);
    drain();
    pulse_clr();

    // 6: asynchronous reset mid-stream with rx_vld high
    for (int i = 0; i < 7; i++) send(8'h60 + 8'(i), 1'b0, 1'b1, 1);
    chk("t6_count7", int'(count), 7);
    @(posedge clk); #1;
    rx_data = 8'h77; rx_vld = 1'b1; rst = 1'b0;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_vld", int'(out_vld), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_no_write", int'(count), 0);
    chk("t6_no_vld", int'(out_vld), 0);
    @(posedge clk); #1 rx_vld = 1'b0;
    send(8'h78, 1'b0, 1'b1, 2);
    chk("t6_rearm_count", int'(count), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
